// File: rtl/vfr_nn_pkg.sv
// Shared sizes, weight address map constants and sequencer states for the vfr_nn controller.
package vfr_nn_pkg;
    localparam int NUM_IN     = 2;
    localparam int NUM_HID    = 4;
    localparam int NUM_OUT    = 10;
    localparam int NUM_W      = 62;
    localparam int HID_BASE   = 0;
    localparam int OUT_BASE   = 12;
    localparam int OUT_STRIDE = 5;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SCAN,
        DONE
    } state_t;
endpackage

// File: rtl/vfr_nn_wbank.sv
// 62-entry weight/bias register file with range-checked write port and flattened read bus.
module vfr_nn_wbank
    import vfr_nn_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_we,
    input  logic                   i_allow,
    input  logic [5:0]             i_addr,
    input  logic [WIDTH-1:0]       i_wdata,
    output logic                   o_err,
    output logic [NUM_W*WIDTH-1:0] o_w
);
    logic [WIDTH-1:0] r_mem [NUM_W];
    logic             r_err;
    logic             w_addr_ok;

    // The address map must tile exactly: 4 hidden neurons x (2 weights + bias), then 10 x (4 + bias).
    if (HID_BASE + NUM_HID * (NUM_IN + 1) != OUT_BASE ||
        OUT_STRIDE != NUM_HID + 1 ||
        OUT_BASE + OUT_STRIDE * NUM_OUT != NUM_W) begin : g_bad_map
        $error("vfr_nn_wbank: inconsistent weight address map");
    end

    assign w_addr_ok = (i_addr < 6'(NUM_W));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_W; k++) r_mem[k] <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= i_we && !(i_allow && w_addr_ok);
            if (i_we && i_allow && w_addr_ok) r_mem[i_addr] <= i_wdata;
        end
    end

    for (genvar g = 0; g < NUM_W; g++) begin : g_flat
        assign o_w[g*WIDTH +: WIDTH] = r_mem[g];
    end

    assign o_err = r_err;
endmodule

// File: rtl/vfr_nn_ctrl.sv
// Sequencer for the 2-4-10 vfr_nn datapath: sample handshake, settle timer, snapshot and
// sequential argmax scan, result handshake. Weights live in vfr_nn_wbank.
module vfr_nn_ctrl
    import vfr_nn_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int FRAC    = 8,
    parameter int LATENCY = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [5:0]               cfg_addr,
    input  logic [WIDTH-1:0]         cfg_wdata,
    output logic                     cfg_err,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_x1,
    input  logic [WIDTH-1:0]         in_x2,
    output logic [WIDTH-1:0]         nn_x1,
    output logic [WIDTH-1:0]         nn_x2,
    output logic [NUM_W*WIDTH-1:0]   nn_w,
    input  logic [NUM_OUT*WIDTH-1:0] nn_y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               out_class,
    output logic [WIDTH-1:0]         out_score,
    output logic                     busy
);
    if (LATENCY < 1 || LATENCY > 255 || FRAC < 0 || FRAC >= WIDTH) begin : g_bad_param
        $error("vfr_nn_ctrl: LATENCY must be 1..255 and FRAC below WIDTH");
    end

    state_t                  r_state;
    state_t                  w_next;
    logic [7:0]              r_cnt;
    logic [3:0]              r_idx;
    logic [3:0]              r_best_idx;
    logic signed [WIDTH-1:0] r_best;
    logic signed [WIDTH-1:0] r_snap [NUM_OUT];
    logic [WIDTH-1:0]        r_nn_x1;
    logic [WIDTH-1:0]        r_nn_x2;
    logic [3:0]              r_class;
    logic [WIDTH-1:0]        r_score;
    logic                    w_accept;
    logic                    w_settled;
    logic                    w_scan_last;
    logic signed [WIDTH-1:0] w_cand;
    logic                    w_gt;

    vfr_nn_wbank #(.WIDTH(WIDTH)) u_wbank (
        .clk     (clk),
        .rst     (rst),
        .i_we    (cfg_we),
        .i_allow (r_state == IDLE),
        .i_addr  (cfg_addr),
        .i_wdata (cfg_wdata),
        .o_err   (cfg_err),
        .o_w     (nn_w)
    );

    assign w_accept    = (r_state == IDLE) && in_valid;
    assign w_settled   = (r_state == SETTLE) && (r_cnt == 8'd0);
    assign w_scan_last = (r_state == SCAN) && (r_idx == 4'(NUM_OUT - 1));
    assign w_cand      = r_snap[r_idx];
    // Strict compare: ties keep the earlier (lower) class index.
    assign w_gt        = w_cand > r_best;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)    w_next = SETTLE;
            SETTLE:  if (w_settled)   w_next = SCAN;
            SCAN:    if (w_scan_last) w_next = DONE;
            DONE:    if (out_ready)   w_next = IDLE;
            default:                  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_best_idx <= '0;
            r_best     <= '0;
            r_nn_x1    <= '0;
            r_nn_x2    <= '0;
            r_class    <= '0;
            r_score    <= '0;
            for (int n = 0; n < NUM_OUT; n++) r_snap[n] <= '0;
        end else begin
            if (w_accept) begin
                r_nn_x1 <= in_x1;
                r_nn_x2 <= in_x2;
                r_cnt   <= 8'(LATENCY - 1);
            end
            if (r_state == SETTLE) begin
                if (r_cnt == 8'd0) begin
                    for (int n = 0; n < NUM_OUT; n++) r_snap[n] <= nn_y[n*WIDTH +: WIDTH];
                    r_best     <= nn_y[0 +: WIDTH];
                    r_best_idx <= 4'd0;
                    r_idx      <= 4'd1;
                end else begin
                    r_cnt <= r_cnt - 8'd1;
                end
            end
            if (r_state == SCAN) begin
                if (w_gt) begin
                    r_best     <= w_cand;
                    r_best_idx <= r_idx;
                end
                if (w_scan_last) begin
                    r_class <= w_gt ? r_idx : r_best_idx;
                    r_score <= w_gt ? w_cand : r_best;
                end
                r_idx <= r_idx + 4'd1;
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = (r_state == DONE);
    assign out_class = r_class;
    assign out_score = r_score;
    assign nn_x1     = r_nn_x1;
    assign nn_x2     = r_nn_x2;
endmodule

// File: tb/tb_vfr_nn_ctrl.sv
// Self-checking bench for vfr_nn_ctrl: directed vector table, multi-cycle corner sequences,
// and randomized transactions against a behavioural argmax / weight-bank model.
module tb_vfr_nn_ctrl;
    localparam int W   = 16;
    localparam int LAT = 16;
    localparam int NW  = 62;
    localparam int NO  = 10;

    logic            clk = 1'b0;
    logic            rst;
    logic            cfg_we;
    logic [5:0]      cfg_addr;
    logic [W-1:0]    cfg_wdata;
    logic            cfg_err;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_x1, in_x2;
    logic [W-1:0]    nn_x1, nn_x2;
    logic [NW*W-1:0] nn_w;
    logic [NO*W-1:0] nn_y;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_class;
    logic [W-1:0]    out_score;
    logic            busy;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] m_w [NW];

    typedef struct {
        logic [NO*W-1:0] y;
        logic [3:0]      cls;
        logic [W-1:0]    score;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;

    vfr_nn_ctrl #(.WIDTH(W), .FRAC(8), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_err(cfg_err), .in_valid(in_valid), .in_ready(in_ready), .in_x1(in_x1),
        .in_x2(in_x2), .nn_x1(nn_x1), .nn_x2(nn_x2), .nn_w(nn_w), .nn_y(nn_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
        .out_score(out_score), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_bank(input string nm);
        logic [NW*W-1:0] e;
        for (int k = 0; k < NW; k++) e[k*W +: W] = m_w[k];
        checks++;
        if (nn_w !== e) begin
            failures++;
            for (int k = 0; k < NW; k++)
                if (nn_w[k*W +: W] !== e[k*W +: W]) begin
                    $display("FAIL %s: nn_w[%0d] got 0x%0h expected 0x%0h", nm, k, nn_w[k*W +: W], e[k*W +: W]);
                    break;
                end
        end
    endtask

    function automatic logic [NO*W-1:0] rand_y();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference argmax: first index holding the largest signed value.
    task automatic model_argmax(input logic [NO*W-1:0] y, output logic [3:0] c, output logic [W-1:0] s);
        int best;
        int v;
        logic signed [W-1:0] t;
        best = 0;
        c = 0;
        for (int n = 0; n < NO; n++) begin
            t = y[n*W +: W];
            v = t;
            if (n == 0 || v > best) begin
                best = v;
                c = 4'(n);
            end
        end
        s = y[c*W +: W];
    endtask

    task automatic cfg_write(input logic [5:0] a, input logic [W-1:0] d, input string nm);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
        if (a < 6'd62) m_w[a] = d;
        chk({nm, "_cfg_err"}, cfg_err, (a >= 6'd62));
        chk_bank({nm, "_bank"});
    endtask

    task automatic run_sample(input logic [W-1:0] x1, input logic [W-1:0] x2,
                              input logic [NO*W-1:0] y, input logic [3:0] exp_c,
                              input logic [W-1:0] exp_s, input bit scramble, input int hold,
                              input bit sw, input logic [5:0] sa, input logic [W-1:0] sd,
                              input string nm);
        int   cycles;
        logic xbad;
        logic stable;
        nn_y = y; in_x1 = x1; in_x2 = x2; in_valid = 1'b1;
        if (sw) begin
            cfg_we = 1'b1; cfg_addr = sa; cfg_wdata = sd; m_w[sa] = sd;
        end
        tick();
        in_valid = 1'b0; cfg_we = 1'b0;
        if (sw) begin
            chk({nm, "_sameedge_err"}, cfg_err, 0);
            chk_bank({nm, "_sameedge_bank"});
        end
        chk({nm, "_busy"}, busy, 1);
        cycles = 0;
        xbad = 1'b0;
        while (!out_valid && cycles < 200) begin
            tick();
            cycles++;
            if (nn_x1 !== x1 || nn_x2 !== x2) xbad = 1'b1;
            if (scramble && cycles >= LAT) nn_y = rand_y();
        end
        chk({nm, "_latency"}, cycles, LAT + 9);
        chk({nm, "_x_held"}, xbad, 0);
        chk({nm, "_class"}, out_class, exp_c);
        chk({nm, "_score"}, out_score, exp_s);
        if (hold > 0) begin
            cfg_we = 1'b1; cfg_addr = 6'd7; cfg_wdata = 16'h1234;
            tick();
            cfg_we = 1'b0;
            chk({nm, "_busy_cfg_err"}, cfg_err, 1);
            stable = 1'b1;
            for (int i = 1; i < hold; i++) begin
                nn_y = rand_y();
                tick();
                if (!out_valid || out_class !== exp_c || out_score !== exp_s || in_ready || cfg_err)
                    stable = 1'b0;
            end
            chk({nm, "_hold_stable"}, stable, 1);
            chk_bank({nm, "_hold_bank"});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({nm, "_valid_drop"}, out_valid, 0);
        chk({nm, "_ready_back"}, in_ready, 1);
    endtask

    function automatic logic [NO*W-1:0] fill(input logic [W-1:0] base);
        logic [NO*W-1:0] y;
        for (int n = 0; n < NO; n++) y[n*W +: W] = base;
        return y;
    endfunction

    initial begin
        logic [NO*W-1:0] y;
        logic [3:0]      c;
        logic [W-1:0]    s;
        int              e, nacc, acc0, acc1;
        logic            pre, seen_valid;

        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; in_valid = 1'b0;
        in_x1 = '0; in_x2 = '0; nn_y = '0; out_ready = 1'b0;
        for (int k = 0; k < NW; k++) m_w[k] = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_class", out_class, 0);
        chk("rst_score", out_score, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_nn_x", {nn_x1, nn_x2}, 0);
        chk_bank("rst_bank");

        cfg_write(6'd0, 16'h04D9, "cfg0");
        cfg_write(6'd61, 16'hFC1A, "cfg61");
        cfg_write(6'd62, 16'hBEEF, "cfg62");
        tick();
        chk("cfg62_err_one_cycle", cfg_err, 0);

        vecs[0].y = fill(16'h0000); vecs[0].y[3*W +: W] = 16'h0180;
        vecs[0].cls = 4'd3; vecs[0].score = 16'h0180;
        vecs[1].y = fill(16'h0000); vecs[1].y[2*W +: W] = 16'h0100; vecs[1].y[7*W +: W] = 16'h0100;
        vecs[1].cls = 4'd2; vecs[1].score = 16'h0100;
        vecs[2].y = fill(16'hFE00); vecs[2].y[9*W +: W] = 16'hFFF0;
        vecs[2].cls = 4'd9; vecs[2].score = 16'hFFF0;
        vecs[3].y = fill(16'h0000); vecs[3].y[0 +: W] = 16'h7FFF;
        vecs[3].cls = 4'd0; vecs[3].score = 16'h7FFF;
        vecs[4].y = fill(16'h8000);
        vecs[4].cls = 4'd0; vecs[4].score = 16'h8000;
        vecs[5].y = fill(16'hFFFF); vecs[5].y[9*W +: W] = 16'h0001;
        vecs[5].cls = 4'd9; vecs[5].score = 16'h0001;
        for (int i = 0; i < 6; i++)
            run_sample(16'h0013 + 16'(i), 16'h00CD, vecs[i].y, vecs[i].cls, vecs[i].score,
                       0, 0, 0, 6'd0, 16'h0, $sformatf("vec%0d", i));

        // Backpressure with nn_y scrambled after the snapshot edge.
        run_sample(16'h0055, 16'hFF80, vecs[0].y, 4'd3, 16'h0180, 1, 20, 0, 6'd0, 16'h0, "bp");

        // Back-to-back: in_valid held high across two samples, consumer always ready.
        y = fill(16'h0000); y[4*W +: W] = 16'h0200;
        nn_y = y; out_ready = 1'b1; in_valid = 1'b1; in_x1 = 16'h0A0A; in_x2 = 16'h0B0B;
        e = 0; nacc = 0; acc0 = 0; acc1 = 0; seen_valid = 1'b0;
        while (nacc < 2 && e < 2 * (LAT + 11) + 5) begin
            pre = in_ready;
            tick();
            e++;
            if (out_valid && !seen_valid) begin
                seen_valid = 1'b1;
                chk("b2b_class", out_class, 4);
            end
            if (pre && in_valid) begin
                if (nacc == 0) begin
                    acc0 = e; in_x1 = 16'h1111; in_x2 = 16'h2222;
                end else begin
                    acc1 = e; in_valid = 1'b0;
                end
                nacc++;
            end
        end
        chk("b2b_accepts", nacc, 2);
        chk("b2b_spacing", acc1 - acc0, LAT + 11);
        chk("b2b_x_second", {nn_x1, nn_x2}, 32'h11112222);
        e = 0;
        while (busy && e < 100) begin tick(); e++; end
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("b2b_drained", busy, 0);

        // Reset while SETTLE has cnt == 5.
        cfg_write(6'd20, 16'h5A5A, "pre_rst_cfg");
        nn_y = vecs[0].y; in_x1 = 16'h0777; in_x2 = 16'h0888; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (LAT - 1 - 5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < NW; k++) m_w[k] = '0;
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_nn_x", {nn_x1, nn_x2}, 0);
        chk_bank("midrst_bank");
        seen_valid = 1'b0;
        repeat (LAT + 15) begin
            tick();
            if (out_valid) seen_valid = 1'b1;
        end
        chk("midrst_no_valid", seen_valid, 0);

        // Randomized transactions against the behavioural model.
        for (int it = 0; it < 25; it++) begin
            int nwr;
            nwr = $urandom_range(0, 2);
            for (int j = 0; j < nwr; j++)
                cfg_write(6'($urandom_range(0, 63)), 16'($urandom), $sformatf("rnd%0d_w%0d", it, j));
            for (int n = 0; n < NO; n++)
                case ($urandom_range(0, 4))
                    0:       y[n*W +: W] = 16'h0100;
                    1:       y[n*W +: W] = 16'hFF00;
                    2:       y[n*W +: W] = 16'h8000;
                    default: y[n*W +: W] = 16'($urandom);
                endcase
            model_argmax(y, c, s);
            run_sample(16'($urandom), 16'($urandom), y, c, s, $urandom_range(0, 1) == 1,
                       $urandom_range(0, 3), $urandom_range(0, 1) == 1,
                       6'($urandom_range(0, 61)), 16'($urandom), $sformatf("rnd%0d", it));
            chk_bank($sformatf("rnd%0d_bank", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
